bit_stuffer_param: RTL and testbench

BIT_STUFFER_PARAM -- requirements
Module: bit_stuffer_param

---
 rtl/bit_stuffer_param.sv | 158 +++++++++++++++
 tb/tb_bit_stuffer_param.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stuffer_param.sv
// rtl/bit_stuffer_param.sv - queued bit stuffer inserting a 0 after RUN_LEN consecutive 1s
// Build option: define BITSTUFF_EOP_STUFF_EN to follow a run-completing last bit with a stuffed 0 carrying out_last.
module bit_stuffer_param #(
    parameter int RUN_LEN    = 6,
    parameter int FIFO_DEPTH = 16,
    parameter int PT_W       = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_bit,
    input  logic            in_last,
    input  logic [PT_W-1:0] in_ptype,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic            out_last,
    output logic [PT_W-1:0] out_ptype,
    output logic            out_stuffed,
    output logic [7:0]      stuff_cnt
);

    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            EW       = PT_W + 2;
    localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]    RUN_LAST = 4'(RUN_LEN - 1);

    typedef enum logic {DATA, STUFF} state_t;

    state_t            state;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [3:0]        run;
    logic [PT_W-1:0]   prev_ptype;
    logic              stuff_last;
    logic              pkt_start;

    logic              empty;
    logic              push;
    logic              pop;
    logic              out_fire;
    logic              head_bit;
    logic              head_last;
    logic [PT_W-1:0]   head_ptype;
    logic              completes_run;
    logic              needs_stuff;
    logic              data_last;

    assign {head_bit, head_last, head_ptype} = mem[rd_ptr];

    assign empty    = (count == '0);
    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign pop      = out_fire && (state == DATA);

    assign completes_run = head_bit && (run == RUN_LAST);

`ifdef BITSTUFF_EOP_STUFF_EN
    // The end-of-packet marker migrates onto the trailing stuffed 0.
    assign needs_stuff = completes_run;
    assign data_last   = head_last && !completes_run;
`else
    assign needs_stuff = completes_run && !head_last;
    assign data_last   = head_last;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_bit, in_last, in_ptype};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // pkt_start marks that the next data beat opens a new packet and resets stuff_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DATA;
            run        <= '0;
            prev_ptype <= '0;
            stuff_last <= 1'b0;
            pkt_start  <= 1'b1;
            stuff_cnt  <= '0;
        end else if (out_fire) begin
            case (state)
                DATA: begin
                    prev_ptype <= head_ptype;
                    if (pkt_start) begin
                        stuff_cnt <= '0;
                    end
                    if (needs_stuff) begin
                        state      <= STUFF;
                        run        <= '0;
                        stuff_last <= head_last;
                        pkt_start  <= 1'b0;
                    end else if (head_last || !head_bit) begin
                        run       <= '0;
                        pkt_start <= head_last;
                    end else begin
                        run       <= run + 4'd1;
                        pkt_start <= 1'b0;
                    end
                end
                STUFF: begin
                    state     <= DATA;
                    run       <= '0;
                    pkt_start <= stuff_last;
                    if (stuff_cnt != 8'hFF) begin
                        stuff_cnt <= stuff_cnt + 8'd1;
                    end
                end
                default: state <= DATA;
            endcase
        end
    end

    always_comb begin
        out_valid   = 1'b0;
        out_bit     = 1'b0;
        out_last    = 1'b0;
        out_ptype   = '0;
        out_stuffed = 1'b0;
        if (state == STUFF) begin
            out_valid   = 1'b1;
            out_last    = stuff_last;
            out_ptype   = prev_ptype;
            out_stuffed = 1'b1;
        end else if (!empty) begin
            out_valid = 1'b1;
            out_bit   = head_bit;
            out_last  = data_last;
            out_ptype = head_ptype;
        end
    end

endmodule

// File: tb/tb_bit_stuffer_param.sv
// tb/tb_bit_stuffer_param.sv - randomized bench for bit_stuffer_param against a packet-level stuffing model
module tb_bit_stuffer_param;

    localparam int RUN_LEN    = 6;
    localparam int FIFO_DEPTH = 16;
    localparam int PT_W       = 2;

`ifdef BITSTUFF_EOP_STUFF_EN
    localparam bit EOP_STUFF = 1'b1;
`else
    localparam bit EOP_STUFF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_bit = 1'b0;
    logic            in_last = 1'b0;
    logic [PT_W-1:0] in_ptype = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_bit;
    logic            out_last;
    logic [PT_W-1:0] out_ptype;
    logic            out_stuffed;
    logic [7:0]      stuff_cnt;

    bit_stuffer_param #(
        .RUN_LEN   (RUN_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PT_W      (PT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .in_last    (in_last),
        .in_ptype   (in_ptype),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_last   (out_last),
        .out_ptype  (out_ptype),
        .out_stuffed(out_stuffed),
        .stuff_cnt  (stuff_cnt)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic            b;
        logic            l;
        logic [PT_W-1:0] pt;
    } bit_t;

    typedef struct {
        logic            b;
        logic            l;
        logic [PT_W-1:0] pt;
        logic            s;
        int              cnt;
    } beat_t;

    bit_t  in_q[$];
    beat_t exp_q[$];

    // Packet-level model: walk the packet, count 1s, emit a stuffed 0 whenever the count hits RUN_LEN.
    task automatic add_packet_bits(input logic [63:0] bits, input int len, input logic [PT_W-1:0] pt);
        int    run;
        int    sc;
        bit_t  x;
        beat_t e;
        logic  b;
        logic  l;
        run = 0;
        sc  = 0;
        for (int i = 0; i < len; i++) begin
            b = bits[i];
            l = (i == len - 1);
            x.b = b; x.l = l; x.pt = pt;
            in_q.push_back(x);
            run = b ? run + 1 : 0;
            e.pt = pt; e.s = 1'b0; e.b = b;
            if (run == RUN_LEN) begin
                run = 0;
                if (l && !EOP_STUFF) begin
                    e.l = 1'b1; e.cnt = sc;
                    exp_q.push_back(e);
                end else begin
                    e.l = 1'b0; e.cnt = sc;
                    exp_q.push_back(e);
                    sc = sc + 1;
                    e.b = 1'b0; e.l = l; e.s = 1'b1; e.cnt = sc;
                    exp_q.push_back(e);
                end
            end else begin
                e.l = l; e.cnt = sc;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic add_random_packet();
        logic [63:0] bits;
        int          len;
        len  = $urandom_range(1, 40);
        bits = '0;
        for (int i = 0; i < len; i++) begin
            bits[i] = ($urandom_range(0, 9) < 8);
        end
        add_packet_bits(bits, len, PT_W'($urandom_range(0, (1 << PT_W) - 1)));
    endtask

    task automatic run_traffic(input int valid_pct, input int ready_pct, input int budget);
        int          cycles;
        logic        pend;
        int          pend_cnt;
        logic        hold;
        logic [31:0] held;
        beat_t       e;
        cycles = 0;
        pend   = 1'b0;
        hold   = 1'b0;
        pend_cnt = 0;
        held   = '0;
        while ((exp_q.size() > 0 || in_q.size() > 0 || pend || hold) && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (pend) begin
                check("stuff_cnt", 32'(stuff_cnt), 32'(pend_cnt));
                pend = 1'b0;
            end
            if (hold) begin
                check("hold", {out_valid, out_bit, out_last, out_stuffed, out_ptype}, held);
                hold = 1'b0;
            end
            in_valid = (in_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
            if (in_valid) begin
                in_bit   = in_q[0].b;
                in_last  = in_q[0].l;
                in_ptype = in_q[0].pt;
                if (in_ready) begin
                    void'(in_q.pop_front());
                end
            end
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {out_bit, out_last, out_stuffed, out_ptype},
                              {e.b, e.l, e.s, e.pt});
                        pend     = 1'b1;
                        pend_cnt = e.cnt;
                    end
                end else begin
                    hold = 1'b1;
                    held = {out_valid, out_bit, out_last, out_stuffed, out_ptype};
                end
            end
        end
        if (cycles >= budget) begin
            check("timeout", 32'd1, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_q.delete();
        exp_q.delete();
    endtask

    task automatic push_raw(input logic [63:0] bits, input int len, input logic [PT_W-1:0] pt,
                            input logic with_last);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = bits[i];
            in_last  = with_last && (i == len - 1);
            in_ptype = pt;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic found;
        int   accepted;
        int   extra;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_fields", {out_bit, out_last, out_stuffed, out_ptype}, 32'd0);
        check("rst_stuff_cnt", 32'(stuff_cnt), 32'd0);
        rst = 1'b0;

        // Directed packets: seven 1s, twelve 1s then 0, exactly six 1s.
        add_packet_bits(64'h7F, 7, 2'd1);
        run_traffic(100, 100, 200);
        add_packet_bits(64'h0FFF, 13, 2'd2);
        run_traffic(100, 100, 200);
        add_packet_bits(64'h3F, 6, 2'd3);
        run_traffic(100, 100, 200);

        for (int k = 0; k < 12; k++) begin
            add_random_packet();
        end
        run_traffic(70, 60, 20000);
        for (int k = 0; k < 8; k++) begin
            add_random_packet();
        end
        run_traffic(100, 100, 5000);
        for (int k = 0; k < 8; k++) begin
            add_random_packet();
        end
        run_traffic(40, 90, 5000);

        // Stall while a stuffed beat is pending.
        reset_dut();
        push_raw(64'b0111111, 7, 2'd2, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_stuffed) found = 1'b1;
            else out_ready = 1'b1;
        end
        out_ready = 1'b0;
        check("stuff_reached", 32'(found), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_stuff", {out_valid, out_bit, out_stuffed, out_ptype}, {3'b101, 2'd2});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("after_stuff", {out_valid, out_bit, out_last, out_stuffed}, 32'b1010);
        check("after_stuff_cnt", 32'(stuff_cnt), 32'd1);

        // Queue fill with the output blocked.
        reset_dut();
        add_packet_bits({$urandom(), $urandom()}, 16, 2'd1);
        accepted = 0;
        extra    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            if (in_q.size() > 0) begin
                in_bit   = in_q[0].b;
                in_last  = in_q[0].l;
                in_ptype = in_q[0].pt;
                if (in_ready) begin
                    void'(in_q.pop_front());
                    accepted++;
                end
            end else begin
                in_bit = 1'b1; in_last = 1'b0; in_ptype = 2'd0;
                if (in_ready) extra++;
            end
        end
        check("fifo_accepted", 32'(accepted), 32'd16);
        check("fifo_holdoff", 32'(extra), 32'd0);
        check("fifo_full_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        run_traffic(0, 100, 500);

        // Reset in the middle of a packet with run at 5.
        reset_dut();
        @(negedge clk);
        out_ready = 1'b1;
        push_raw(64'h1F, 5, 2'd0, 1'b0);
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        push_raw(64'b11101, 5, 2'd0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_stuff_cnt", 32'(stuff_cnt), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        add_packet_bits(64'h3F, 6, 2'd3);
        run_traffic(100, 100, 200);
        add_packet_bits(64'h7F, 7, 2'd0);
        run_traffic(100, 100, 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
